// File: rtl/jkff_pkg.sv
// Shared types and the JK next-state rule for the flop-bank monitor.
package jkff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } mon_state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic logic jk_next(
        input logic q,
        input logic j,
        input logic k
    );
        logic r;
        unique case ({j, k})
            JK_HOLD: r = q;
            JK_RST:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TOG:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jkff_model_lane.sv
// One-bit JK reference flop with output compare.
module jkff_model_lane
    import jkff_pkg::*;
(
    input  logic clk,
    input  logic cl,
    input  logic i_load,
    input  logic i_adv,
    input  logic i_j,
    input  logic i_k,
    input  logic i_q,
    input  logic i_qb,
    output logic o_miss
);

    logic r_model;
    logic w_jk_x;

    // Unknown J/K cannot be modelled, so it is reported as a lane error.
    assign w_jk_x = $isunknown({i_j, i_k});

    assign o_miss = (i_q != r_model)
                  | (i_qb != ~i_q)
                  | w_jk_x;

    always_ff @(posedge clk or negedge cl) begin
        if (!cl) begin
            r_model <= 1'b0;
        end else if (i_load) begin
            r_model <= jk_next(i_q, i_j, i_k);
        end else if (i_adv) begin
            r_model <= jk_next(r_model, i_j, i_k);
        end
    end

endmodule

// File: rtl/jkff_monitor.sv
// Passive checker for a bank of JK flops: reference model,
// sticky per-lane errors, saturating stats and a latched FAIL.
module jkff_monitor
    import jkff_pkg::*;
#(
    parameter int N       = 4,
    parameter int CNT_W   = 16,
    parameter int MAX_ERR = 8
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             en,
    input  logic             clr_stats,
    input  logic [N-1:0]     j,
    input  logic [N-1:0]     k,
    input  logic [N-1:0]     q,
    input  logic [N-1:0]     qb,
    output logic             err,
    output logic [N-1:0]     err_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             fail,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic             r_err;
    logic [N-1:0]     r_mask;
    logic [CNT_W-1:0] r_ecnt;
    logic [CNT_W-1:0] r_ccnt;

    logic [N-1:0]     w_miss;
    logic             w_legal;
    logic             w_load;
    logic             w_chk;
    logic             w_bad;
    logic             w_hit;

    assign w_legal = &(q ^ qb);
    assign w_load  = (r_state == SYNC) & en & w_legal;
    assign w_chk   = (r_state == CHECK) & en;
    assign w_bad   = w_chk & (|w_miss) & ~clr_stats;

    // The increment that lands exactly on MAX_ERR trips FAIL.
    assign w_hit = (MAX_ERR != 0)
                 && w_bad
                 && (r_ecnt != CNT_MAX)
                 && ((33'(r_ecnt) + 33'd1) == 33'(MAX_ERR));

    for (genvar g = 0; g < N; g++) begin : g_lane
        jkff_model_lane u_lane (
            .clk    (clk),
            .cl     (cl),
            .i_load (w_load),
            .i_adv  (w_chk),
            .i_j    (j[g]),
            .i_k    (k[g]),
            .i_q    (q[g]),
            .i_qb   (qb[g]),
            .o_miss (w_miss[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) w_state_nxt = SYNC;
            end
            SYNC: begin
                if (!en)          w_state_nxt = IDLE;
                else if (w_legal) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (!en)        w_state_nxt = IDLE;
                else if (w_hit) w_state_nxt = FAIL;
            end
            FAIL: begin
                if (clr_stats) w_state_nxt = SYNC;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cl) begin
        if (!cl) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_mask  <= '0;
            r_ecnt  <= '0;
            r_ccnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_bad & ~w_hit;
            if (clr_stats) begin
                r_mask <= '0;
                r_ecnt <= '0;
                r_ccnt <= '0;
            end else begin
                if (w_chk) begin
                    r_mask <= r_mask | w_miss;
                    if (r_ccnt != CNT_MAX) r_ccnt <= r_ccnt + CNT_ONE;
                end
                if (w_bad && (r_ecnt != CNT_MAX)) begin
                    r_ecnt <= r_ecnt + CNT_ONE;
                end
            end
        end
    end

    assign err      = r_err;
    assign err_mask = r_mask;
    assign err_cnt  = r_ecnt;
    assign cyc_cnt  = r_ccnt;
    assign fail     = (r_state == FAIL);
    assign state    = r_state;

endmodule
